// File: rtl/piso_frame_tx_if.sv
// Word handshake between a producer and the framed serial transmitter.
interface piso_frame_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] datain;
   logic             valid;
   logic             ready;

   modport master (output datain, output valid, input ready);
   modport slave  (input datain, input valid, output ready);
endinterface

// File: rtl/piso_frame_tx.sv
// Framed PISO transmitter: start bit, data LSB first, optional parity, stop bit.
// Each bit lasts CLKS_PER_BIT clocks; the line idles high.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | line high, ready for a word
//   S_START  | driving the start bit (low)
//   S_DATA   | driving shift-register LSB, one bit per period
//   S_PARITY | driving the parity bit
//   S_STOP   | driving the stop bit (high); done pulses on exit
module piso_frame_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic               clk,
   input  logic               reset,
   piso_frame_tx_if.slave     bus,
   output logic               dataout,
   output logic               busy,
   output logic               done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    clk_cnt, clk_cnt_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shr;
   logic             parity, parity_nxt;
   logic             dataout_nxt, done_nxt, bit_end;

   assign shreg_shr = shreg >> 1;
   assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign bus.ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         parity  <= 1'b0;
         dataout <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         clk_cnt <= clk_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         parity  <= parity_nxt;
         dataout <= dataout_nxt;
         done    <= done_nxt;
      end
   end

   // dataout is registered, so each branch chooses the level for the state being entered
   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      parity_nxt  = parity;
      dataout_nxt = dataout;
      done_nxt    = 1'b0;
      unique case (state)
         S_IDLE: begin
            dataout_nxt = 1'b1;
            if (bus.valid) begin
               shreg_nxt   = bus.datain;
               parity_nxt  = (^bus.datain) ^ (PARITY_ODD != 0);
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               dataout_nxt = 1'b0;
               state_nxt   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               dataout_nxt = shreg[0];
               state_nxt   = S_DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               clk_cnt_nxt = '0;
               shreg_nxt   = shreg_shr;
               if (bit_cnt == BW'(WIDTH - 1)) begin
                  if (PARITY_EN != 0) begin
                     dataout_nxt = parity;
                     state_nxt   = S_PARITY;
                  end else begin
                     dataout_nxt = 1'b1;
                     state_nxt   = S_STOP;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + BW'(1);
                  dataout_nxt = shreg_shr[0];
               end
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_nxt = '0;
               dataout_nxt = 1'b1;
               state_nxt   = S_STOP;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               clk_cnt_nxt = '0;
               dataout_nxt = 1'b1;
               done_nxt    = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: four parameter sets share one stimulus stream and a
// bit-queue reference model, plus directed frame tables for the default set.
module tb_piso_frame_tx;
   localparam int NCFG = 4;
   localparam logic [3:0][7:0] P_W  = {8'd5, 8'd8, 8'd8, 8'd8};
   localparam logic [3:0][7:0] P_C  = {8'd3, 8'd1, 8'd4, 8'd1};
   localparam logic [3:0]      P_PE = 4'b1011;
   localparam logic [3:0]      P_PO = 4'b0010;

   logic       clk;
   logic       reset;
   logic       valid;
   logic [7:0] datain;
   logic       dout_a  [NCFG];
   logic       ready_a [NCFG];
   logic       busy_a  [NCFG];
   logic       done_a  [NCFG];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W = int'(P_W[g]);
      piso_frame_tx_if #(.WIDTH(W)) bus ();
      assign bus.datain = datain[W-1:0];
      assign bus.valid  = valid;
      assign ready_a[g] = bus.ready;
      piso_frame_tx #(
         .WIDTH(W), .CLKS_PER_BIT(int'(P_C[g])),
         .PARITY_EN(int'(P_PE[g])), .PARITY_ODD(int'(P_PO[g]))
      ) dut (
         .clk(clk), .reset(reset), .bus(bus.slave),
         .dataout(dout_a[g]), .busy(busy_a[g]), .done(done_a[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: an accepted word becomes the list of line levels, one per clock.
   bit   line_q [NCFG][$];
   logic e_dout [NCFG];
   logic e_busy [NCFG];
   logic e_done [NCFG];

   function automatic int frame_clks(int g);
      return (int'(P_W[g]) + 2 + int'(P_PE[g])) * int'(P_C[g]);
   endfunction

   task automatic push_bit(int g, bit b);
      for (int r = 0; r < int'(P_C[g]); r++) line_q[g].push_back(b);
   endtask

   task automatic model_step();
      for (int g = 0; g < NCFG; g++) begin
         if (reset) begin
            line_q[g].delete();
            e_dout[g] = 1'b1; e_busy[g] = 1'b0; e_done[g] = 1'b0;
         end else if (line_q[g].size() != 0) begin
            e_dout[g] = line_q[g].pop_front(); e_busy[g] = 1'b1; e_done[g] = 1'b0;
         end else if (e_busy[g]) begin
            e_dout[g] = 1'b1; e_busy[g] = 1'b0; e_done[g] = 1'b1;
         end else begin
            e_done[g] = 1'b0;
            if (valid) begin
               bit par;
               par = P_PO[g];
               push_bit(g, 1'b0);
               for (int i = 0; i < int'(P_W[g]); i++) begin
                  push_bit(g, datain[i]);
                  par = par ^ datain[i];
               end
               if (P_PE[g]) push_bit(g, par);
               push_bit(g, 1'b1);
               e_dout[g] = line_q[g].pop_front();
               e_busy[g] = 1'b1;
            end
         end
      end
   endtask

   task automatic model_compare();
      for (int g = 0; g < NCFG; g++) begin
         logic [3:0] got, exp;
         got = {dout_a[g], ready_a[g], busy_a[g], done_a[g]};
         exp = {e_dout[g], ~e_busy[g], e_busy[g], e_done[g]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL model cfg%0d t=%0t {dout,ready,busy,done} got=%b exp=%b", g, $time, got, exp);
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      model_compare();
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_a[0] | busy_a[1] | busy_a[2] | busy_a[3]) !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", 32'(n < 300), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  word;
      logic [0:10] line;
   } rec_t;
   rec_t recs [5];

   initial begin
      int first_done [NCFG];
      logic [0:23] bb;

      recs[0] = '{8'hA5, 11'b01010010101};
      recs[1] = '{8'h01, 11'b01000000011};
      recs[2] = '{8'h00, 11'b00000000001};
      recs[3] = '{8'hFF, 11'b01111111101};
      recs[4] = '{8'h3C, 11'b00011110001};
      bb = 24'b0_00000000_0_1_1_0_11111111_0_1_1;

      reset = 1'b1; valid = 1'b0; datain = 8'h00;
      repeat (3) tick();
      for (int g = 0; g < NCFG; g++)
         check($sformatf("reset_state_cfg%0d", g),
               32'({dout_a[g], ready_a[g], busy_a[g], done_a[g]}), 32'b1100);
      reset = 1'b0;
      tick();

      // Directed frames on cfg0 plus done timing on every parameter set
      for (int r = 0; r < 5; r++) begin
         wait_idle();
         datain = recs[r].word; valid = 1'b1;
         tick();
         valid = 1'b0;
         for (int g = 0; g < NCFG; g++) first_done[g] = -1;
         for (int i = 0; i < 60; i++) begin
            if (i <= 10)
               check($sformatf("frame_%0h_bit%0d {dout,ready}", recs[r].word, i),
                     32'({dout_a[0], ready_a[0]}), 32'({recs[r].line[i], 1'b0}));
            for (int g = 0; g < NCFG; g++)
               if (done_a[g] === 1'b1 && first_done[g] < 0) first_done[g] = i;
            tick();
         end
         for (int g = 0; g < NCFG; g++)
            check($sformatf("done_edge_%0h_cfg%0d", recs[r].word, g),
                  32'(first_done[g]), 32'(frame_clks(g)));
      end

      // valid pulsed mid-frame is ignored
      wait_idle();
      datain = 8'hA5; valid = 1'b1;
      tick();
      valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i <= 10) check($sformatf("ignore_bit%0d", i), 32'(dout_a[0]), 32'(recs[0].line[i]));
         if (i == 11) check("ignore_done", 32'(done_a[0]), 32'd1);
         if (i >= 12) check($sformatf("ignore_no_frame%0d", i), 32'(busy_a[0]), 32'd0);
         valid = (i == 2);
         datain = (i == 2) ? 8'h3C : 8'h00;
         tick();
      end

      // back-to-back with valid held high
      wait_idle();
      tick();
      datain = 8'h00; valid = 1'b1;
      tick();
      datain = 8'hFF;
      for (int i = 0; i < 24; i++) begin
         check($sformatf("b2b_%0d {dout,done}", i), 32'({dout_a[0], done_a[0]}),
               32'({bb[i], 1'(i == 11 || i == 23)}));
         if (i == 12) valid = 1'b0;
         tick();
      end

      // reset mid-frame, then a clean frame right after
      wait_idle();
      datain = 8'hA5; valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("midreset_outputs", 32'({dout_a[0], ready_a[0], busy_a[0], done_a[0]}), 32'b1100);
      reset = 1'b0; valid = 1'b1;
      tick();
      valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i <= 10) check($sformatf("postreset_bit%0d", i), 32'(dout_a[0]), 32'(recs[0].line[i]));
         else check("postreset_done", 32'(done_a[0]), 32'd1);
         tick();
      end

      // reset wins over a simultaneous accept
      wait_idle();
      reset = 1'b1; valid = 1'b1; datain = 8'h5A;
      tick();
      check("reset_priority", 32'({ready_a[0], busy_a[0]}), 32'b10);
      reset = 1'b0; valid = 1'b0;
      tick();

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         valid  = 1'($urandom_range(0, 1));
         datain = 8'($urandom);
         reset  = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0; valid = 1'b0;
      wait_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
